// File: rtl/axi_dw_rd_slot_alloc.sv
// axi_dw_rd_slot_alloc: admits AR requests into outstanding-read slots and retires them by R ID.
// Ports:
//   clk_i, rst_i                      clock, asynchronous active-high reset
//   ar_valid_i/ar_id_i/ar_len_i       AR request, ar_len_i = narrow beats minus 1
//   ar_ready_o/ar_slot_o              accept (no free slot or same ID busy stalls), granted slot
//   r_valid_i/r_ready_i/r_id_i/r_last_i  narrow R beat and downstream ready
//   r_hit_o/r_slot_o                  R ID matches a busy slot, and which one
//   busy_cnt_o                        registered count of busy slots
//   protocol_err_o                    sticky: orphan R, early last or missing last
module axi_dw_rd_slot_alloc #(
   parameter int NumSlots = 4,
   parameter int IdWidth  = 4,
   parameter int LenWidth = 8,
   localparam int SlotW   = NumSlots > 1 ? $clog2(NumSlots) : 1,
   localparam int CntW    = $clog2(NumSlots + 1)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                ar_valid_i,
   input  logic [IdWidth-1:0]  ar_id_i,
   input  logic [LenWidth-1:0] ar_len_i,
   output logic                ar_ready_o,
   output logic [SlotW-1:0]    ar_slot_o,
   input  logic                r_valid_i,
   input  logic                r_ready_i,
   input  logic [IdWidth-1:0]  r_id_i,
   input  logic                r_last_i,
   output logic                r_hit_o,
   output logic [SlotW-1:0]    r_slot_o,
   output logic [CntW-1:0]     busy_cnt_o,
   output logic                protocol_err_o
);
   logic [NumSlots-1:0]                busy_q, busy_d;
   logic [NumSlots-1:0][IdWidth-1:0]   id_q, id_d;
   logic [NumSlots-1:0][LenWidth-1:0]  cnt_q, cnt_d;
   logic                               err_d, id_busy, ar_hs, r_hs;
   logic [CntW-1:0]                    pop;
   // Descending scan so the last assignment wins: lowest free slot, and the
   // single busy slot matching the R ID (same-ID serialisation keeps it unique).
   always_comb begin
      id_busy   = 1'b0;
      ar_slot_o = '0;
      r_hit_o   = 1'b0;
      r_slot_o  = '0;
      for (int i = NumSlots - 1; i >= 0; i--) begin
         if (busy_q[i] && id_q[i] == ar_id_i) id_busy = 1'b1;
         if (!busy_q[i]) ar_slot_o = SlotW'(i);
         if (busy_q[i] && id_q[i] == r_id_i) begin
            r_hit_o  = 1'b1;
            r_slot_o = SlotW'(i);
         end
      end
   end
   assign ar_ready_o = ~&busy_q & ~id_busy;
   assign ar_hs      = ar_valid_i & ar_ready_o;
   assign r_hs       = r_valid_i & r_ready_i;
   // The granted slot is free and the R slot is busy, so both updates never collide.
   always_comb begin
      busy_d = busy_q;
      id_d   = id_q;
      cnt_d  = cnt_q;
      err_d  = protocol_err_o;
      if (r_hs && !r_hit_o) err_d = 1'b1;
      if (r_hs && r_hit_o) begin
         if (r_last_i) begin
            busy_d[r_slot_o] = 1'b0;
            if (cnt_q[r_slot_o] != '0) err_d = 1'b1;
         end else if (cnt_q[r_slot_o] == '0) err_d = 1'b1;
         else cnt_d[r_slot_o] = cnt_q[r_slot_o] - 1'b1;
      end
      if (ar_hs) begin
         busy_d[ar_slot_o] = 1'b1;
         id_d[ar_slot_o]   = ar_id_i;
         cnt_d[ar_slot_o]  = ar_len_i;
      end
      pop = '0;
      for (int i = 0; i < NumSlots; i++) pop = pop + CntW'(busy_d[i]);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q         <= '0;
         id_q           <= '0;
         cnt_q          <= '0;
         busy_cnt_o     <= '0;
         protocol_err_o <= 1'b0;
      end else begin
         busy_q         <= busy_d;
         id_q           <= id_d;
         cnt_q          <= cnt_d;
         busy_cnt_o     <= pop;
         protocol_err_o <= err_d;
      end
   end
endmodule

// File: tb/tb_axi_dw_rd_slot_alloc.sv
// tb_axi_dw_rd_slot_alloc: directed stimulus checked each cycle against a slot-table model.
module tb_axi_dw_rd_slot_alloc;
   localparam int N = 4;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ar_valid = 1'b0;
   logic [3:0] ar_id = '0;
   logic [7:0] ar_len = '0;
   logic       ar_ready;
   logic [1:0] ar_slot;
   logic       r_valid = 1'b0;
   logic       r_ready = 1'b0;
   logic [3:0] r_id = '0;
   logic       r_last = 1'b0;
   logic       r_hit;
   logic [1:0] r_slot;
   logic [2:0] busy_cnt;
   logic       err;
   int n_chk = 0;
   int n_fail = 0;
   bit m_busy [N];
   int m_id [N];
   int m_rem [N];
   bit m_err;

   axi_dw_rd_slot_alloc #(.NumSlots(N), .IdWidth(4), .LenWidth(8)) dut (
      .clk_i(clk), .rst_i(rst),
      .ar_valid_i(ar_valid), .ar_id_i(ar_id), .ar_len_i(ar_len),
      .ar_ready_o(ar_ready), .ar_slot_o(ar_slot),
      .r_valid_i(r_valid), .r_ready_i(r_ready), .r_id_i(r_id), .r_last_i(r_last),
      .r_hit_o(r_hit), .r_slot_o(r_slot),
      .busy_cnt_o(busy_cnt), .protocol_err_o(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int free_idx();
      for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
      return -1;
   endfunction

   function automatic int id_match(input int id);
      for (int i = 0; i < N; i++) if (m_busy[i] && m_id[i] == id) return i;
      return -1;
   endfunction

   function automatic int n_busy();
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(m_busy[i]);
      return c;
   endfunction

   // Model: a table of outstanding reads, each with its ID and remaining beats.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_busy[i] <= 1'b0;
            m_id[i]   <= 0;
            m_rem[i]  <= 0;
         end
         m_err <= 1'b0;
      end else begin
         if (r_valid && r_ready) begin
            if (id_match(int'(r_id)) < 0) m_err <= 1'b1;
            else if (r_last) begin
               if (m_rem[id_match(int'(r_id))] != 0) m_err <= 1'b1;
               m_busy[id_match(int'(r_id))] <= 1'b0;
            end else if (m_rem[id_match(int'(r_id))] == 0) m_err <= 1'b1;
            else m_rem[id_match(int'(r_id))] <= m_rem[id_match(int'(r_id))] - 1;
         end
         if (ar_valid && free_idx() >= 0 && id_match(int'(ar_id)) < 0) begin
            m_busy[free_idx()] <= 1'b1;
            m_id[free_idx()]   <= int'(ar_id);
            m_rem[free_idx()]  <= int'(ar_len);
         end
      end
   end

   always @(negedge clk) begin
      chk("ar_ready", int'(ar_ready), int'(free_idx() >= 0 && id_match(int'(ar_id)) < 0));
      if (free_idx() >= 0 && id_match(int'(ar_id)) < 0) chk("ar_slot", int'(ar_slot), free_idx());
      chk("r_hit", int'(r_hit), int'(id_match(int'(r_id)) >= 0));
      if (id_match(int'(r_id)) >= 0) chk("r_slot", int'(r_slot), id_match(int'(r_id)));
      chk("busy_cnt", int'(busy_cnt), n_busy());
      chk("protocol_err", int'(err), int'(m_err));
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic ar_issue(input int id, input int len);
      ar_valid = 1'b1;
      ar_id = 4'(id);
      ar_len = 8'(len);
      tick();
      ar_valid = 1'b0;
   endtask

   task automatic r_set(input int id, input bit last);
      r_valid = 1'b1;
      r_ready = 1'b1;
      r_id = 4'(id);
      r_last = last;
   endtask

   task automatic rbeat(input int id, input bit last);
      r_set(id, last);
      tick();
      r_valid = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("rst_busy_cnt", int'(busy_cnt), 0);
      chk("rst_ar_ready", int'(ar_ready), 1);
      chk("rst_err", int'(err), 0);
      // basic read id=3 len=2
      ar_valid = 1'b1; ar_id = 4'd3; ar_len = 8'd2;
      #1;
      chk("t1_ready", int'(ar_ready), 1);
      chk("t1_slot", int'(ar_slot), 0);
      tick();
      ar_valid = 1'b0;
      chk("t1_busy1", int'(busy_cnt), 1);
      r_set(3, 1'b0);
      #1;
      chk("t1_hit", int'(r_hit), 1);
      tick();
      rbeat(3, 1'b0);
      rbeat(3, 1'b1);
      chk("t1_busy0", int'(busy_cnt), 0);
      chk("t1_err", int'(err), 0);
      // fill all slots, then free slot 2 while id=5 waits
      ar_issue(1, 0); ar_issue(2, 0); ar_issue(3, 0); ar_issue(4, 0);
      chk("t2_full", int'(busy_cnt), 4);
      ar_valid = 1'b1; ar_id = 4'd5; ar_len = 8'd0;
      r_set(3, 1'b1);
      #1;
      chk("t2_stall", int'(ar_ready), 0);
      tick();
      r_valid = 1'b0;
      #1;
      chk("t2_ready", int'(ar_ready), 1);
      chk("t2_slot", int'(ar_slot), 2);
      tick();
      ar_valid = 1'b0;
      chk("t2_full2", int'(busy_cnt), 4);
      rbeat(1, 1'b1); rbeat(2, 1'b1); rbeat(4, 1'b1); rbeat(5, 1'b1);
      chk("t2_drain", int'(busy_cnt), 0);
      // same-ID stall released by R last in the same cycle
      ar_issue(7, 0);
      ar_valid = 1'b1; ar_id = 4'd7; ar_len = 8'd0;
      r_set(7, 1'b1);
      #1;
      chk("t3_stall", int'(ar_ready), 0);
      tick();
      r_valid = 1'b0;
      #1;
      chk("t3_ready", int'(ar_ready), 1);
      tick();
      ar_valid = 1'b0;
      chk("t3_busy", int'(busy_cnt), 1);
      rbeat(7, 1'b1);
      // out-of-order return
      ar_issue(1, 1);
      ar_issue(2, 0);
      r_set(2, 1'b1);
      #1;
      chk("t4_slot1", int'(r_slot), 1);
      tick();
      r_set(1, 1'b0);
      #1;
      chk("t4_slot0", int'(r_slot), 0);
      tick();
      rbeat(1, 1'b1);
      chk("t4_busy", int'(busy_cnt), 0);
      chk("t4_err", int'(err), 0);
      // orphan R
      rbeat(9, 1'b1);
      chk("t5_orphan", int'(err), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_clr", int'(err), 0);
      // early last, then missing last
      ar_issue(6, 3);
      rbeat(6, 1'b0);
      rbeat(6, 1'b1);
      chk("t5_early_busy", int'(busy_cnt), 0);
      chk("t5_early_err", int'(err), 1);
      ar_issue(8, 0);
      rbeat(8, 1'b0);
      chk("t5_miss_busy", int'(busy_cnt), 1);
      rbeat(8, 1'b1);
      tick();
      tick();
      chk("t5_sticky", int'(err), 1);
      chk("t5_alloc_ok", int'(ar_ready), 1);
      // asynchronous reset mid-flight
      ar_issue(1, 2); ar_issue(2, 2); ar_issue(3, 2);
      chk("t6_busy3", int'(busy_cnt), 3);
      ar_id = 4'd1;
      #1 rst = 1'b1;
      #1;
      chk("t6_busy0", int'(busy_cnt), 0);
      chk("t6_ready", int'(ar_ready), 1);
      chk("t6_err", int'(err), 0);
      #1 rst = 1'b0;
      r_valid = 1'b1; r_ready = 1'b1; r_id = 4'd1; r_last = 1'b0;
      #1;
      chk("t6_nohit", int'(r_hit), 0);
      tick();
      r_valid = 1'b0;
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
